aes_key_expander: RTL and testbench
===================================

# aes_key_expander

Iterative AES key-schedule generator: the producer of the flattened expanded-key bus that every round-key XOR stage consumes. It accepts a 128/192/256-bit cipher key and computes one 32-bit schedule word per clock into a packed round-key register. When done, it presents all Nr+1 round keys with round key 0 in the most significant 128 bits, the layout the round stages slice from. It sits between key load and the cipher round pipeline.

## Interface
- NK, 4, key length in 32-bit words; legal values 4, 6, 8 (Nr = NK+6, total words NW = 4*(NK+7))
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  one-cycle request; captures key_in and begins expansion
- key_in  input  NK*32  cipher key, word 0 in bits [NK*32-1 -: 32]
- busy  output  1  high while expansion is in progress
- done  output  1  one-cycle pulse when the last word is written
- key_valid  output  1  level; round_keys complete and stable
- round_keys  output  NW*32  word i in bits [NW*32-1-32*i -: 32]; round r key = words 4r..4r+3

## Operation
- Reset (async, rst_n low): state IDLE; busy=0, done=0, key_valid=0, round_keys=0, counters=0, rcon=8'h01.
- States:
  - IDLE: on start, load words 0..NK-1 from key_in, set i=NK, imod=0, rcon=8'h01, busy=1, key_valid=0, go to EXPAND.
  - EXPAND: each cycle write word i, i++, imod = (imod==NK-1) ? 0 : imod+1. After writing word NW-1: busy=0, done=1, key_valid=1, return to IDLE.
- Word rule, with temp = w[i-1] read from round_keys:
  - imod==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}; then rcon = xtime(rcon), i.e. rcon<<1 with ^8'h1b on carry-out.
  - NK==8 and imod==4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp.
- RotWord {a,b,c,d} -> {b,c,d,a}. SubWord applies the S-box to each byte. All arithmetic is 8-bit GF(2^8) or 32-bit XOR; no carries.
- start while busy: ignored; expansion continues undisturbed.
- start in the same cycle that done is raised: ignored (FSM is still in EXPAND).
- start in IDLE after completion: key_valid drops at that edge, and round_keys words NK.. hold stale data until overwritten.
- Reset mid-expansion: everything returns to reset values immediately; no partial key_valid.
- Consumers may use round_keys only while key_valid=1.

## Timing
- start sampled at edge E0: words 0..NK-1 are visible after E0, and busy goes high.
- Word i (i>=NK) is written at edge E0+(i-NK+1).
- Last word, done=1, key_valid=1 and busy=0 all take effect at edge E0+(NW-NK): 40, 46 and 52 cycles for NK=4, 6, 8.
- done is high for exactly one cycle.
- Back-to-back: earliest accepted restart is the cycle after done, so there is one idle cycle between expansions.
- Single-cycle combinational path per word: 4 S-box lookups + 2 XOR levels.

## Structure
- Shared package aes_pkg holds:
  - constant WORD_W=32
  - functions nw(NK)=4*(NK+7) and nr(NK)=NK+6
  - xtime function
  - rotword function
  - FSM state enum (IDLE, EXPAND)
- Sub-module aes_sbox: combinational 8-bit forward S-box, instanced 4× to form SubWord. The same module is reused by the SubBytes stage.

## Test plan
- NK=4, key_in=2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - done exactly 40 cycles after start
  - w4=a0fafe17; w40..w43=d014f9a8 c9ee2589 e13f0cc8 b6630ca6
- NK=6, key_in=8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b:
  - done at 46 cycles
  - w6=fe0c91f7; w51=01002202
- NK=8, key_in=603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - done at 52 cycles
  - w8=9ba35411; w12=a8b09c1a (imod==4 SubWord path); w59=706c631e
- NK=4, extra start pulses at cycles 5 and 40 (same cycle as done) -> both ignored, results still match vector 1; a start at cycle 41 is accepted and key_valid falls.
- NK=4, rst_n low at cycle 20 -> busy, done, key_valid and round_keys read 0 asynchronously; a new start after reset completes correctly.
- Random keys (≥100) versus a software reference model -> every round_keys word matches; done fires once per accepted start.

Source files
------------

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the key schedule and the round datapath.
//   WORD_W   : width of one schedule word
//   nw(nk)   : total schedule words for a key of nk 32-bit words
//   nr(nk)   : number of cipher rounds for a key of nk 32-bit words
//   xtime    : multiply a GF(2^8) element by x (used to step rcon)
//   rotword  : cyclic left rotation of a word by one byte
//   state_e  : key expander FSM states
// ---------------------------------------------------------------------------
package aes_pkg;

   localparam int WORD_W = 32;

   typedef enum logic {
      IDLE,
      EXPAND
   } state_e;

   function automatic int nw(input int nk);
      return 4 * (nk + 7);
   endfunction

   function automatic int nr(input int nk);
      return nk + 6;
   endfunction

   // Reduction polynomial x^8+x^4+x^3+x+1 folds back in when bit 7 shifts out.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // {a,b,c,d} -> {b,c,d,a}
   function automatic logic [WORD_W-1:0] rotword(input logic [WORD_W-1:0] w);
      return {w[WORD_W-9:0], w[WORD_W-1 -: 8]};
   endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational forward AES S-box, one byte wide. Shared by the key
// schedule (SubWord) and the cipher SubBytes stage.
//   a : input byte
//   y : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
   input  logic [7:0] a,
   output logic [7:0] y
);

   // Row r of the table holds entries 16r..16r+15, entry 0 in the top byte.
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry k sits at bits [2047-8k -: 8]; 2047-8k equals {~k, 3'b111}.
   assign y = SBOX_TABLE[{~a, 3'b111} -: 8];

endmodule

// File: rtl/aes_key_expander.sv
// ---------------------------------------------------------------------------
// aes_key_expander
// Iterative AES key schedule: one 32-bit word per clock into a packed
// round-key register. Word 0 (round key 0) occupies the most significant
// bits of round_keys, which is how the round stages slice it.
//   NK         : key length in 32-bit words (4, 6 or 8)
//   clk        : rising-edge clock
//   rst_n      : asynchronous active-low reset
//   start      : one-cycle request, captures key_in when idle
//   key_in     : cipher key, word 0 in the top 32 bits
//   busy       : expansion in progress
//   done       : one-cycle pulse when the last word is written
//   key_valid  : round_keys complete and stable
//   round_keys : all NW schedule words, word 0 in the top 32 bits
// ---------------------------------------------------------------------------
module aes_key_expander
   import aes_pkg::*;
#(
   parameter int NK = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic [NK*WORD_W-1:0]     key_in,
   output logic                     busy,
   output logic                     done,
   output logic                     key_valid,
   output logic [nw(NK)*WORD_W-1:0] round_keys
);

   localparam int NW = nw(NK);

   state_e                    state_q;
   state_e                    state_d;
   logic [0:NW-1][WORD_W-1:0] w_q;
   logic [5:0]                widx_q;
   logic [2:0]                imod_q;
   logic [7:0]                rcon_q;

   logic                      load_key;
   logic                      write_word;
   logic                      last_word;

   logic [WORD_W-1:0]         prev_word;
   logic [WORD_W-1:0]         back_word;
   logic [WORD_W-1:0]         sub_in;
   logic [WORD_W-1:0]         sub_out;
   logic [WORD_W-1:0]         temp_word;
   logic [WORD_W-1:0]         next_word;

   // Ascending packed word array: element 0 lands in the top bits.
   assign round_keys = w_q;

   // Four S-boxes form SubWord; shared by the rcon and the NK==8 mid-key paths.
   for (genvar b = 0; b < 4; b++) begin : g_subword
      aes_sbox u_sbox (
         .a (sub_in[8*b +: 8]),
         .y (sub_out[8*b +: 8])
      );
   end

   // Next schedule word from w[i-1] and w[i-NK]. Only imod==0 rotates
   // before substitution; the NK==8, imod==4 case substitutes unrotated.
   always_comb begin
      prev_word = w_q[widx_q - 6'd1];
      back_word = w_q[widx_q - 6'(NK)];
      sub_in    = (imod_q == 3'd0) ? rotword(prev_word) : prev_word;
      temp_word = prev_word;
      if (imod_q == 3'd0) begin
         temp_word = sub_out ^ {rcon_q, 24'h000000};
      end else if (NK == 8 && imod_q == 3'd4) begin
         temp_word = sub_out;
      end
      next_word = back_word ^ temp_word;
   end

   // Next-state and control decode. start is only honoured in IDLE, so a
   // request during expansion or on the finishing edge is dropped.
   always_comb begin
      state_d    = state_q;
      load_key   = 1'b0;
      write_word = 1'b0;
      last_word  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               load_key = 1'b1;
               state_d  = EXPAND;
            end
         end
         EXPAND: begin
            write_word = 1'b1;
            if (widx_q == 6'(NW - 1)) begin
               last_word = 1'b1;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, schedule storage and status flags. On a restart only the key
   // words are loaded; words NK.. keep stale data until rewritten, which is
   // why key_valid drops on the loading edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         w_q       <= '0;
         widx_q    <= '0;
         imod_q    <= '0;
         rcon_q    <= 8'h01;
         busy      <= 1'b0;
         done      <= 1'b0;
         key_valid <= 1'b0;
      end else begin
         state_q <= state_d;
         done    <= 1'b0;
         if (load_key) begin
            w_q[0:NK-1] <= key_in;
            widx_q      <= 6'(NK);
            imod_q      <= 3'd0;
            rcon_q      <= 8'h01;
            busy        <= 1'b1;
            key_valid   <= 1'b0;
         end
         if (write_word) begin
            w_q[widx_q] <= next_word;
            widx_q      <= widx_q + 6'd1;
            imod_q      <= (imod_q == 3'(NK - 1)) ? 3'd0 : imod_q + 3'd1;
            if (imod_q == 3'd0) begin
               rcon_q <= xtime(rcon_q);
            end
            if (last_word) begin
               busy      <= 1'b0;
               done      <= 1'b1;
               key_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_aes_key_expander.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expander
// Drives one expander per key length (NK=4,6,8). Each accepted start pushes
// its expected schedule, finishing cycle and spot words into a queue; the
// monitor pops an entry whenever a DUT pulses done and compares.
// ---------------------------------------------------------------------------
module tb_aes_key_expander;

   logic          clk;
   logic          rst_n;
   logic [2:0]    start_v;
   logic [127:0]  key4;
   logic [191:0]  key6;
   logic [255:0]  key8;
   logic [1407:0] rk4;
   logic [1663:0] rk6;
   logic [1919:0] rk8;
   logic [2:0]    busy_all;
   logic [2:0]    done_all;
   logic [2:0]    kv_all;
   logic [1919:0] rk_all [3];

   int cyc = 0;
   int vectors = 0;
   int miscompares = 0;

   typedef struct {
      int             dut;
      int             nk;
      int             done_cyc;
      logic [1919:0]  keys;
      int             n_spot;
      logic [4:0][5:0]  spot_idx;
      logic [4:0][31:0] spot_val;
   } expect_t;

   expect_t    sbq[$];
   logic [7:0] sbox_tab [256];

   aes_key_expander #(.NK(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start_v[0]), .key_in(key4),
      .busy(busy_all[0]), .done(done_all[0]), .key_valid(kv_all[0]), .round_keys(rk4));
   aes_key_expander #(.NK(6)) dut6 (
      .clk(clk), .rst_n(rst_n), .start(start_v[1]), .key_in(key6),
      .busy(busy_all[1]), .done(done_all[1]), .key_valid(kv_all[1]), .round_keys(rk6));
   aes_key_expander #(.NK(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start_v[2]), .key_in(key8),
      .busy(busy_all[2]), .done(done_all[2]), .key_valid(kv_all[2]), .round_keys(rk8));

   // Left-align every bus so word i is at [1919-32i -: 32] for all DUTs.
   assign rk_all[0] = {rk4, 512'b0};
   assign rk_all[1] = {rk6, 256'b0};
   assign rk_all[2] = rk8;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int k = 0; k < 8; k++) begin
         if (b[k]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // S-box built from its definition: multiplicative inverse then affine map.
   task automatic buildSbox();
      logic [7:0]  inv;
      logic [15:0] dd;
      for (int v = 0; v < 256; v++) begin
         inv = 8'h00;
         for (int c = 1; c < 256; c++)
            if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
         dd = {inv, inv};
         sbox_tab[v] = inv ^ dd[14:7] ^ dd[13:6] ^ dd[12:5] ^ dd[11:4] ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subWordRef(input logic [31:0] w);
      return {sbox_tab[w[31:24]], sbox_tab[w[23:16]], sbox_tab[w[15:8]], sbox_tab[w[7:0]]};
   endfunction

   function automatic logic [1919:0] expandRef(input int nk, input logic [255:0] key);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1919:0] r;
      int            nwl;
      nwl = 4 * (nk + 7);
      rc  = 8'h01;
      r   = '0;
      for (int k = 0; k < nk; k++) w[k] = key[32*nk-1-32*k -: 32];
      for (int i = nk; i < nwl; i++) begin
         t = w[i-1];
         if (i % nk == 0) begin
            t  = subWordRef({t[23:0], t[31:24]}) ^ {rc, 24'h000000};
            rc = gmul(rc, 8'h02);
         end else if (nk == 8 && i % nk == 4) begin
            t = subWordRef(t);
         end
         w[i] = w[i-nk] ^ t;
      end
      for (int i = 0; i < nwl; i++) r[1919-32*i -: 32] = w[i];
      return r;
   endfunction

   // ---------------- checking ----------------
   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
      vectors++;
      if (actual !== required) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h required %0h", name, actual, required);
      end
   endtask

   // Monitor: every done pulse consumes exactly one pending expectation.
   always @(negedge clk) begin
      expect_t e;
      int      bad;
      int      first_bad;
      int      nwd;
      for (int d = 0; d < 3; d++) begin
         if (rst_n && done_all[d]) begin
            if (sbq.size() == 0) begin
               vectors++;
               miscompares++;
               $display("[TB] FAIL unexpected done on dut nk=%0d: got done=1 required done=0", 4 + 2*d);
            end else begin
               e = sbq.pop_front();
               checkOutput("done from dut index", 64'(d), 64'(e.dut));
               checkOutput($sformatf("nk=%0d done cycle", e.nk), 64'(cyc), 64'(e.done_cyc));
               checkOutput($sformatf("nk=%0d key_valid at done", e.nk), 64'(kv_all[d]), 64'd1);
               checkOutput($sformatf("nk=%0d busy at done", e.nk), 64'(busy_all[d]), 64'd0);
               nwd = 4 * (e.nk + 7);
               bad = 0;
               first_bad = 0;
               for (int i = 0; i < nwd; i++) begin
                  if (rk_all[d][1919-32*i -: 32] !== e.keys[1919-32*i -: 32]) begin
                     if (bad == 0) first_bad = i;
                     bad++;
                  end
               end
               vectors++;
               if (bad != 0) begin
                  miscompares++;
                  $display("[TB] FAIL nk=%0d round_keys: %0d words differ, w%0d got %08h required %08h",
                           e.nk, bad, first_bad, rk_all[d][1919-32*first_bad -: 32],
                           e.keys[1919-32*first_bad -: 32]);
               end
               for (int s = 0; s < e.n_spot; s++)
                  checkOutput($sformatf("nk=%0d w%0d", e.nk, e.spot_idx[s]),
                              64'(rk_all[d][1919-32*int'(e.spot_idx[s]) -: 32]), 64'(e.spot_val[s]));
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   // Called at a negedge; the start is sampled at the next posedge (E0).
   task automatic applyStimulus(input int d, input logic [255:0] key, input bit accepted,
                                input int n_spot, input logic [4:0][5:0] s_idx,
                                input logic [4:0][31:0] s_val, output int e0);
      expect_t e;
      int      nk;
      nk = 4 + 2*d;
      case (d)
         0:       key4 = key[127:0];
         1:       key6 = key[191:0];
         default: key8 = key;
      endcase
      start_v[d] = 1'b1;
      e0 = cyc + 1;
      if (accepted) begin
         e.dut      = d;
         e.nk       = nk;
         e.done_cyc = e0 + 3*nk + 28;
         e.keys     = expandRef(nk, key);
         e.n_spot   = n_spot;
         e.spot_idx = s_idx;
         e.spot_val = s_val;
         sbq.push_back(e);
      end
      @(negedge clk);
      start_v[d] = 1'b0;
   endtask

   task automatic waitCyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic waitIdle(input int budget);
      int n;
      n = 0;
      while (sbq.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) begin
         vectors++;
         miscompares++;
         $display("[TB] FAIL timeout: %0d expansions pending after %0d cycles, required 0", sbq.size(), budget);
         sbq.delete();
      end
      @(negedge clk);
   endtask

   localparam logic [255:0] VEC4 = 256'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [255:0] VEC6 = 256'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
   localparam logic [255:0] VEC8 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
   localparam logic [4:0][5:0]  IDX4 = {6'd4, 6'd43, 6'd42, 6'd41, 6'd40};
   localparam logic [4:0][31:0] VAL4 = {32'ha0fafe17, 32'hb6630ca6, 32'he13f0cc8, 32'hc9ee2589, 32'hd014f9a8};
   localparam logic [4:0][5:0]  IDX6 = {6'd0, 6'd0, 6'd0, 6'd51, 6'd6};
   localparam logic [4:0][31:0] VAL6 = {32'h0, 32'h0, 32'h0, 32'h01002202, 32'hfe0c91f7};
   localparam logic [4:0][5:0]  IDX8 = {6'd0, 6'd0, 6'd59, 6'd12, 6'd8};
   localparam logic [4:0][31:0] VAL8 = {32'h0, 32'h0, 32'h706c631e, 32'ha8b09c1a, 32'h9ba35411};

   initial begin
      logic [255:0] rkey;
      int           e0;
      int           dummy;
      rst_n   = 1'b0;
      start_v = 3'b000;
      key4    = '0;
      key6    = '0;
      key8    = '0;
      buildSbox();
      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         checkOutput($sformatf("reset nk=%0d busy", 4 + 2*d), 64'(busy_all[d]), 64'd0);
         checkOutput($sformatf("reset nk=%0d done", 4 + 2*d), 64'(done_all[d]), 64'd0);
         checkOutput($sformatf("reset nk=%0d key_valid", 4 + 2*d), 64'(kv_all[d]), 64'd0);
         checkOutput($sformatf("reset nk=%0d round_keys nonzero", 4 + 2*d), 64'(|rk_all[d]), 64'd0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("[TB] FIPS-197 vectors");
      applyStimulus(0, VEC4, 1'b1, 5, IDX4, VAL4, e0);
      checkOutput("nk=4 busy after start", 64'(busy_all[0]), 64'd1);
      checkOutput("nk=4 key word 0 visible", 64'(rk_all[0][1919 -: 32]), 64'h2b7e1516);
      waitIdle(100);
      applyStimulus(1, VEC6, 1'b1, 2, IDX6, VAL6, e0);
      waitIdle(100);
      applyStimulus(2, VEC8, 1'b1, 3, IDX8, VAL8, e0);
      waitIdle(100);

      $display("[TB] ignored starts while busy and on the done edge");
      applyStimulus(0, VEC4, 1'b1, 5, IDX4, VAL4, e0);
      waitCyc(e0 + 4);
      applyStimulus(0, {256{1'b1}}, 1'b0, 0, '0, '0, dummy);
      waitCyc(e0 + 39);
      applyStimulus(0, {256{1'b1}}, 1'b0, 0, '0, '0, dummy);
      applyStimulus(0, VEC4, 1'b1, 5, IDX4, VAL4, dummy);
      checkOutput("nk=4 key_valid after restart", 64'(kv_all[0]), 64'd0);
      checkOutput("nk=4 busy after restart", 64'(busy_all[0]), 64'd1);
      waitIdle(100);

      $display("[TB] reset mid-expansion");
      applyStimulus(0, VEC4, 1'b1, 5, IDX4, VAL4, e0);
      waitCyc(e0 + 19);
      checkOutput("nk=4 busy before reset", 64'(busy_all[0]), 64'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("async reset busy", 64'(busy_all[0]), 64'd0);
      checkOutput("async reset done", 64'(done_all[0]), 64'd0);
      checkOutput("async reset key_valid", 64'(kv_all[0]), 64'd0);
      checkOutput("async reset round_keys nonzero", 64'(|rk_all[0]), 64'd0);
      sbq.delete();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      applyStimulus(0, VEC4, 1'b1, 5, IDX4, VAL4, e0);
      waitIdle(100);

      $display("[TB] random keys");
      for (int r = 0; r < 120; r++) begin
         rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         applyStimulus(r % 3, rkey, 1'b1, 0, '0, '0, e0);
         waitIdle(100);
      end

      repeat (5) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation still running, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
